// File: rtl/dram_req_scheduler.sv
// -----------------------------------------------------------------------------
// dram_req_scheduler
//
// Shares one DRAM device between two simple requesters (for example the
// instruction-side and data-side slave wrappers). Requests are arbitrated
// round-robin in IDLE. The block then sequences precharge (PRE), activate
// (ACT) and a single column command (COL). Reads wait in RDWAIT for
// DRAM_valid, and the answer is held in RESP until it is accepted.
//
// Build option (macro DRAM_OPEN_ROW_EN):
//   defined   : open-row policy. The row stays open after a response; a hit
//               goes IDLE -> COL, and a miss goes through PRE then ACT.
//   undefined : closed-page policy. Every response handshake is followed by
//               a PRE close, so IDLE always starts with ACT. No row
//               comparator is built.
//
// Parameters:
//   T_RCD  cycles spent in ACT (>= 1)
//   T_RP   cycles spent in PRE (>= 1)
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   req_valid[1:0]           per-requester request valid (held until ready)
//   req_ready[1:0]           one-hot single-cycle accept pulse
//   req_write[1:0]           1 = write, 0 = read
//   req_addr[63:0]           byte address, requester 0 in [31:0], 1 in [63:32]
//   req_wdata[63:0]          write data, packed like req_addr
//   req_wen[7:0]             active-low byte enables, requester 0 in [3:0]
//   rsp_valid / rsp_ready    response handshake
//   rsp_id                   requester being answered
//   rsp_rdata[31:0]          last captured read data
//   DRAM_CSn/RASn/CASn       DRAM strobes, active-low
//   DRAM_WEn[3:0]            DRAM byte write enables, active-low
//   DRAM_A[10:0]             row or column address
//   DRAM_D[31:0]             write data
//   DRAM_valid / DRAM_Q      read data return
// -----------------------------------------------------------------------------
module dram_req_scheduler #(
    parameter int T_RCD = 5,
    parameter int T_RP  = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [1:0]  req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_wen,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_rdata,
    output logic        DRAM_CSn,
    output logic        DRAM_RASn,
    output logic        DRAM_CASn,
    output logic [3:0]  DRAM_WEn,
    output logic [10:0] DRAM_A,
    output logic [31:0] DRAM_D,
    input  logic        DRAM_valid,
    input  logic [31:0] DRAM_Q
);

    localparam int T_MAX = (T_RCD > T_RP) ? T_RCD : T_RP;
    localparam int CW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;
    localparam logic [CW-1:0] RP_LAST  = CW'(T_RP - 1);
    localparam logic [CW-1:0] RCD_LAST = CW'(T_RCD - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_PRE    = 3'd1;
    localparam logic [2:0] S_ACT    = 3'd2;
    localparam logic [2:0] S_COL    = 3'd3;
    localparam logic [2:0] S_RDWAIT = 3'd4;
    localparam logic [2:0] S_RESP   = 3'd5;

    logic [2:0]    r_state;
    logic [CW-1:0] r_cnt;          // cycles already spent in PRE/ACT
    logic          r_rr_ptr;       // preferred requester when both are valid
    logic [10:0]   r_open_row;
    logic          r_id;
    logic          r_write;
    logic [10:0]   r_row;
    logic [9:0]    r_col;
    logic [31:0]   r_wdata;
    logic [3:0]    r_wen;
    logic [31:0]   r_rdata;

    logic          w_both;
    logic          w_gnt_id;
    logic          w_accept;
    logic [31:0]   w_sel_addr;
    logic [10:0]   w_sel_row;
    logic          w_unused;

    assign w_both     = &req_valid;
    assign w_gnt_id   = w_both ? r_rr_ptr : req_valid[1];
    assign w_accept   = (r_state == S_IDLE) && (|req_valid);
    assign w_sel_addr = w_gnt_id ? req_addr[63:32] : req_addr[31:0];
    assign w_sel_row  = w_sel_addr[22:12];
    // Byte offset and high address bits carry no meaning for this device.
    assign w_unused   = ^{w_sel_addr[31:23], w_sel_addr[1:0]};

`ifdef DRAM_OPEN_ROW_EN
    logic r_row_open;
    logic w_hit;
    assign w_hit = r_row_open && (w_sel_row == r_open_row);
`else
    logic r_closing;               // PRE entered after a response, exits to IDLE
`endif

    // Gated with rst so no accept can be seen while reset is asserted.
    assign req_ready = (w_accept && rst) ? (w_gnt_id ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_valid = (r_state == S_RESP);
    assign rsp_id    = r_id;
    assign rsp_rdata = r_rdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_rr_ptr   <= 1'b0;
            r_open_row <= '0;
            r_id       <= 1'b0;
            r_write    <= 1'b0;
            r_row      <= '0;
            r_col      <= '0;
            r_wdata    <= '0;
            r_wen      <= 4'hf;
            r_rdata    <= '0;
`ifdef DRAM_OPEN_ROW_EN
            r_row_open <= 1'b0;
`else
            r_closing  <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_id    <= w_gnt_id;
                        r_write <= req_write[w_gnt_id];
                        r_row   <= w_sel_row;
                        r_col   <= w_sel_addr[11:2];
                        r_wdata <= w_gnt_id ? req_wdata[63:32] : req_wdata[31:0];
                        r_wen   <= w_gnt_id ? req_wen[7:4] : req_wen[3:0];
                        r_cnt   <= '0;
                        if (w_both) r_rr_ptr <= ~w_gnt_id;
`ifdef DRAM_OPEN_ROW_EN
                        if (w_hit)           r_state <= S_COL;
                        else if (r_row_open) r_state <= S_PRE;
                        else                 r_state <= S_ACT;
`else
                        r_state <= S_ACT;
`endif
                    end
                end
                S_PRE: begin
                    if (r_cnt == RP_LAST) begin
                        r_cnt <= '0;
`ifdef DRAM_OPEN_ROW_EN
                        r_row_open <= 1'b0;
                        r_state    <= S_ACT;
`else
                        r_closing <= 1'b0;
                        r_state   <= r_closing ? S_IDLE : S_ACT;
`endif
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_ACT: begin
                    if (r_cnt == RCD_LAST) begin
                        r_cnt      <= '0;
                        r_open_row <= r_row;
`ifdef DRAM_OPEN_ROW_EN
                        r_row_open <= 1'b1;
`endif
                        r_state    <= S_COL;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_COL: begin
                    r_state <= r_write ? S_RESP : S_RDWAIT;
                end
                S_RDWAIT: begin
                    if (DRAM_valid) begin
                        r_rdata <= DRAM_Q;
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
`ifdef DRAM_OPEN_ROW_EN
                        r_state <= S_IDLE;
`else
                        r_closing <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= S_PRE;
`endif
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // DRAM pins are decoded from state, phase count and the latched request.
    always_comb begin
        DRAM_CSn  = (r_state == S_IDLE);
        DRAM_RASn = 1'b1;
        DRAM_CASn = 1'b1;
        DRAM_WEn  = 4'hf;
        DRAM_A    = '0;
        DRAM_D    = '0;
        case (r_state)
            S_PRE: begin
                if (r_cnt == '0) begin
                    DRAM_RASn = 1'b0;
                    DRAM_WEn  = 4'h0;
                    DRAM_A    = r_open_row;
                end
            end
            S_ACT: begin
                if (r_cnt == '0) begin
                    DRAM_RASn = 1'b0;
                    DRAM_A    = r_row;
                end
            end
            S_COL: begin
                DRAM_CASn = 1'b0;
                DRAM_A    = {1'b0, r_col};
                if (r_write) begin
                    DRAM_WEn = r_wen;
                    DRAM_D   = r_wdata;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dram_req_scheduler.sv
// -----------------------------------------------------------------------------
// tb_dram_req_scheduler
//
// Directed bench for dram_req_scheduler with default timing (T_RCD=T_RP=5).
// A per-cycle table of {inputs, expected outputs} covers the basic write,
// the requester-1 read and the row-miss sequence. Hand-written sequences
// cover round-robin alternation, a stalled response and reset during ACT.
// Expected pin values depend on DRAM_OPEN_ROW_EN, matching the build.
// -----------------------------------------------------------------------------
module tb_dram_req_scheduler;

    logic        clk, rst;
    logic [1:0]  req_valid, req_ready, req_write;
    logic [63:0] req_addr, req_wdata;
    logic [7:0]  req_wen;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [31:0] rsp_rdata;
    logic        DRAM_CSn, DRAM_RASn, DRAM_CASn;
    logic [3:0]  DRAM_WEn;
    logic [10:0] DRAM_A;
    logic [31:0] DRAM_D;
    logic        DRAM_valid;
    logic [31:0] DRAM_Q;

    int n_chk = 0;
    int n_err = 0;

    dram_req_scheduler #(.T_RCD(5), .T_RP(5)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wen(req_wen),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_rdata(rsp_rdata),
        .DRAM_CSn(DRAM_CSn), .DRAM_RASn(DRAM_RASn), .DRAM_CASn(DRAM_CASn),
        .DRAM_WEn(DRAM_WEn), .DRAM_A(DRAM_A), .DRAM_D(DRAM_D),
        .DRAM_valid(DRAM_valid), .DRAM_Q(DRAM_Q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [1:0]  v, w;
        logic [63:0] addr, wdata;
        logic [7:0]  wen;
        logic        rrdy, dv;
        logic [31:0] q;
        logic [1:0]  e_rdy;
        logic        e_rv, e_rid;
        logic [31:0] e_rdata;
        logic        e_cs, e_ras, e_cas;
        logic [3:0]  e_we;
        logic [10:0] e_a;
        logic [31:0] e_d;
    } vec_t;

    vec_t tbl[$];
    vec_t cur;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic ex(input logic [1:0] rdy, input logic rv, input logic rid,
                      input logic [31:0] rd, input logic cs, input logic ras,
                      input logic cas, input logic [3:0] we, input logic [10:0] a,
                      input logic [31:0] d);
        vec_t t;
        t = cur;
        t.e_rdy = rdy; t.e_rv = rv; t.e_rid = rid; t.e_rdata = rd;
        t.e_cs = cs; t.e_ras = ras; t.e_cas = cas; t.e_we = we; t.e_a = a; t.e_d = d;
        tbl.push_back(t);
    endtask

    task automatic pidle(input logic [1:0] rdy, input logic [31:0] rd);
        ex(rdy, 1'b0, 1'b0, rd, 1'b1, 1'b1, 1'b1, 4'hf, 11'h0, 32'h0);
    endtask
    task automatic pbusy(input logic [31:0] rd);
        ex(2'b00, 1'b0, 1'b0, rd, 1'b0, 1'b1, 1'b1, 4'hf, 11'h0, 32'h0);
    endtask
    task automatic pbusy4(input logic [31:0] rd);
        for (int i = 0; i < 4; i++) pbusy(rd);
    endtask
    task automatic pras(input logic [10:0] a, input logic [3:0] we, input logic [31:0] rd);
        ex(2'b00, 1'b0, 1'b0, rd, 1'b0, 1'b0, 1'b1, we, a, 32'h0);
    endtask
    task automatic pcol(input logic [3:0] we, input logic [10:0] a, input logic [31:0] d,
                        input logic [31:0] rd);
        ex(2'b00, 1'b0, 1'b0, rd, 1'b0, 1'b1, 1'b0, we, a, d);
    endtask
    task automatic presp(input logic rid, input logic [31:0] rd);
        ex(2'b00, 1'b1, rid, rd, 1'b0, 1'b1, 1'b1, 4'hf, 11'h0, 32'h0);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_ready(input int budget, output logic [1:0] g);
        g = 2'b00;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (req_ready != 2'b00) begin
                g = req_ready;
                return;
            end
            tick();
        end
        n_chk++; n_err++;
        $display("FAIL wait_ready: no accept within %0d cycles", budget);
    endtask

    task automatic wait_rsp(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (rsp_valid) return;
            tick();
        end
        n_chk++; n_err++;
        $display("FAIL wait_rsp: no rsp_valid within %0d cycles", budget);
    endtask

    task automatic wait_act(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!DRAM_RASn && DRAM_WEn == 4'hf) return;
            tick();
        end
        n_chk++; n_err++;
        $display("FAIL wait_act: no activate within %0d cycles", budget);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".req_ready"}, req_ready, 2'b00);
        chk({tag, ".rsp_valid"}, rsp_valid, 1'b0);
        chk({tag, ".rsp_id"},    rsp_id,    1'b0);
        chk({tag, ".rsp_rdata"}, rsp_rdata, 32'h0);
        chk({tag, ".CSn"},       DRAM_CSn,  1'b1);
        chk({tag, ".RASn"},      DRAM_RASn, 1'b1);
        chk({tag, ".CASn"},      DRAM_CASn, 1'b1);
        chk({tag, ".WEn"},       DRAM_WEn,  4'hf);
        chk({tag, ".A"},         DRAM_A,    11'h0);
        chk({tag, ".D"},         DRAM_D,    32'h0);
    endtask

    logic [1:0] g;

    initial begin
        rst = 1'b1; req_valid = 2'b00; req_write = 2'b00; req_addr = '0;
        req_wdata = '0; req_wen = 8'hff; rsp_ready = 1'b0; DRAM_valid = 1'b0; DRAM_Q = '0;
        #2 rst = 1'b0;
        req_valid = 2'b11;
        #1 chk_reset_vals("reset");
        @(posedge clk); tick();
        rst = 1'b1; req_valid = 2'b00;

        // ---- table: write (req0), read (req1), row-change write (req0) ----
        cur = '{v: 2'b01, w: 2'b01, addr: 64'h0000_0000_0000_1008,
                wdata: 64'h0000_0000_DEAD_BEEF, wen: 8'hf0, rrdy: 1'b0, dv: 1'b0,
                q: 32'h0, default: '0};
        pidle(2'b01, 32'h0);
        cur.v = 2'b00;
        pras(11'h001, 4'hf, 32'h0);
        pbusy4(32'h0);
        pcol(4'h0, 11'h002, 32'hDEADBEEF, 32'h0);
        cur.rrdy = 1'b1; presp(1'b0, 32'h0);
        cur.rrdy = 1'b0;
`ifndef DRAM_OPEN_ROW_EN
        pras(11'h001, 4'h0, 32'h0);
        pbusy4(32'h0);
`endif
        pidle(2'b00, 32'h0);

        cur.v = 2'b10; cur.w = 2'b00; cur.addr = 64'h0000_1008_0000_0000;
        cur.wdata = 64'h0; cur.wen = 8'hff;
        pidle(2'b10, 32'h0);
        cur.v = 2'b00;
`ifndef DRAM_OPEN_ROW_EN
        pras(11'h001, 4'hf, 32'h0);
        pbusy4(32'h0);
`endif
        pcol(4'hf, 11'h002, 32'h0, 32'h0);
        pbusy(32'h0);
        cur.dv = 1'b1; cur.q = 32'hDEADBEEF; pbusy(32'h0);
        cur.dv = 1'b0; cur.q = 32'h0; cur.rrdy = 1'b1; presp(1'b1, 32'hDEADBEEF);
        cur.rrdy = 1'b0;
`ifndef DRAM_OPEN_ROW_EN
        pras(11'h001, 4'h0, 32'hDEADBEEF);
        pbusy4(32'hDEADBEEF);
`endif
        pidle(2'b00, 32'hDEADBEEF);

        cur.v = 2'b01; cur.w = 2'b01; cur.addr = 64'h0000_0000_0000_2000;
        cur.wdata = 64'h0000_0000_CAFE_F00D; cur.wen = 8'hf5;
        pidle(2'b01, 32'hDEADBEEF);
        cur.v = 2'b00;
`ifdef DRAM_OPEN_ROW_EN
        pras(11'h001, 4'h0, 32'hDEADBEEF);
        pbusy4(32'hDEADBEEF);
`endif
        pras(11'h002, 4'hf, 32'hDEADBEEF);
        pbusy4(32'hDEADBEEF);
        pcol(4'h5, 11'h000, 32'hCAFEF00D, 32'hDEADBEEF);
        cur.rrdy = 1'b1; presp(1'b0, 32'hDEADBEEF);
        cur.rrdy = 1'b0;
`ifndef DRAM_OPEN_ROW_EN
        pras(11'h002, 4'h0, 32'hDEADBEEF);
        pbusy4(32'hDEADBEEF);
`endif
        pidle(2'b00, 32'hDEADBEEF);

        for (int i = 0; i < tbl.size(); i++) begin
            req_valid = tbl[i].v; req_write = tbl[i].w; req_addr = tbl[i].addr;
            req_wdata = tbl[i].wdata; req_wen = tbl[i].wen; rsp_ready = tbl[i].rrdy;
            DRAM_valid = tbl[i].dv; DRAM_Q = tbl[i].q;
            @(negedge clk);
            chk($sformatf("vec%0d.req_ready", i), req_ready, tbl[i].e_rdy);
            chk($sformatf("vec%0d.rsp_valid", i), rsp_valid, tbl[i].e_rv);
            if (tbl[i].e_rv) chk($sformatf("vec%0d.rsp_id", i), rsp_id, tbl[i].e_rid);
            chk($sformatf("vec%0d.rsp_rdata", i), rsp_rdata, tbl[i].e_rdata);
            chk($sformatf("vec%0d.CSn", i),  DRAM_CSn,  tbl[i].e_cs);
            chk($sformatf("vec%0d.RASn", i), DRAM_RASn, tbl[i].e_ras);
            chk($sformatf("vec%0d.CASn", i), DRAM_CASn, tbl[i].e_cas);
            chk($sformatf("vec%0d.WEn", i),  DRAM_WEn,  tbl[i].e_we);
            chk($sformatf("vec%0d.A", i),    DRAM_A,    tbl[i].e_a);
            chk($sformatf("vec%0d.D", i),    DRAM_D,    tbl[i].e_d);
            tick();
        end

        // ---- both requesters valid continuously: grants alternate 0,1,0,1 ----
        req_write = 2'b11; req_addr = {32'h2000, 32'h2000};
        req_wdata = {32'h1111_1111, 32'h2222_2222}; req_wen = 8'h00;
        rsp_ready = 1'b1; req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            wait_ready(100, g);
            chk($sformatf("rr_grant%0d", k), g, (k % 2 == 1) ? 2'b10 : 2'b01);
            tick();
            @(negedge clk);
            chk($sformatf("rr_pulse%0d", k), req_ready, 2'b00);
            tick();
        end
        req_valid = 2'b00;
        repeat (20) tick();

        // ---- response stalled 10 cycles with requester 1 waiting ----
        rsp_ready = 1'b0; req_write = 2'b10; req_addr = {32'h2000, 32'h2004};
        DRAM_valid = 1'b1; DRAM_Q = 32'h1234_5678; req_valid = 2'b01;
        wait_ready(50, g);
        chk("stall_grant", g, 2'b01);
        tick();
        req_valid = 2'b10;
        wait_rsp(100);
        chk("stall_rsp_id", rsp_id, 1'b0);
        chk("stall_rdata", rsp_rdata, 32'h1234_5678);
        tick();
        DRAM_Q = 32'hFFFF_0000;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("stall%0d.rsp_valid", i), rsp_valid, 1'b1);
            chk($sformatf("stall%0d.rsp_rdata", i), rsp_rdata, 32'h1234_5678);
            chk($sformatf("stall%0d.req_ready", i), req_ready, 2'b00);
            tick();
        end
        rsp_ready = 1'b1;
        wait_ready(50, g);
        chk("after_stall_grant", g, 2'b10);
        tick();
        req_valid = 2'b00; DRAM_valid = 1'b0;
        repeat (20) tick();

        // ---- reset while requester 1 is in ACT ----
        req_write = 2'b11; req_addr = {32'h5000, 32'h4000}; req_valid = 2'b11;
        wait_ready(50, g);
        chk("pre_rst_grant0", g, 2'b01);
        tick();
        req_valid = 2'b10;
        wait_ready(60, g);
        chk("pre_rst_grant1", g, 2'b10);
        tick();
        wait_act(20);
        tick();
        rst = 1'b0; req_valid = 2'b11;
        #1 chk_reset_vals("rst_in_act");
        @(posedge clk); tick();
        rst = 1'b1;
        req_valid = 2'b10; req_write = 2'b00; req_addr = {32'h1008, 32'h0};
        DRAM_valid = 1'b1; DRAM_Q = 32'h0BAD_F00D; rsp_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_grant", req_ready, 2'b10);
        tick();
        req_valid = 2'b00;
        @(negedge clk);
        chk("post_rst_RASn", DRAM_RASn, 1'b0);
        chk("post_rst_WEn", DRAM_WEn, 4'hf);
        chk("post_rst_A", DRAM_A, 11'h001);
        tick();
        wait_rsp(30);
        chk("post_rst_rsp_id", rsp_id, 1'b1);
        chk("post_rst_rdata", rsp_rdata, 32'h0BAD_F00D);
        tick();
        DRAM_valid = 1'b0;
        repeat (15) tick();
        req_write = 2'b11; req_valid = 2'b11;
        wait_ready(30, g);
        chk("rr_after_reset", g, 2'b01);
        tick();
        req_valid = 2'b00;
        repeat (20) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
